// File: rtl/seq_shifter_if.sv
// Request/response bundle for the iterative shifter: operand and mode in,
// result/flags out, each direction with its own valid/ready pair.
interface seq_shifter_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) ();
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         Control;
    logic [WIDTH-1:0]   A;
    logic [SHAMT_W-1:0] Amount;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   Answer;
    logic               Cout;
    logic               Err;
    logic               Busy;

    modport master (
        output in_valid, Control, A, Amount, out_ready,
        input  in_ready, out_valid, Answer, Cout, Err, Busy
    );

    modport slave (
        input  in_valid, Control, A, Amount, out_ready,
        output in_ready, out_valid, Answer, Cout, Err, Busy
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: SLL/SRL/SRA/ROL/ROR, one bit position per clock,
// IDLE -> SHIFT -> DONE with a held result until the consumer takes it.
module seq_shifter #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    seq_shifter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [2:0] C_SLL = 3'b000;
    localparam logic [2:0] C_SRL = 3'b001;
    localparam logic [2:0] C_SRA = 3'b010;
    localparam logic [2:0] C_ROL = 3'b011;
    localparam logic [2:0] C_ROR = 3'b100;
    localparam logic [2:0] C_RSV = 3'b101;

    state_t             r_state;
    logic [WIDTH-1:0]   r_answer;
    logic               r_cout;
    logic               r_err;
    logic [2:0]         r_ctrl;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH:0]     w_step;

    // One-bit step of the selected mode; returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] shift_step(input logic [2:0] mode,
                                                  input logic [WIDTH-1:0] val);
        logic [WIDTH:0] res;
        case (mode)
            C_SLL:   res = {val[WIDTH-1], val[WIDTH-2:0], 1'b0};
            C_SRL:   res = {val[0], 1'b0, val[WIDTH-1:1]};
            C_SRA:   res = {val[0], val[WIDTH-1], val[WIDTH-1:1]};
            C_ROL:   res = {val[WIDTH-1], val[WIDTH-2:0], val[WIDTH-1]};
            C_ROR:   res = {val[0], val[0], val[WIDTH-1:1]};
            default: res = {1'b0, val};
        endcase
        return res;
    endfunction

    assign w_step = shift_step(r_ctrl, r_answer);

    // Control FSM and result datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_answer <= {WIDTH{1'b0}};
            r_cout   <= 1'b0;
            r_err    <= 1'b0;
            r_ctrl   <= 3'b000;
            r_cnt    <= {SHAMT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_answer <= bus.A;
                        r_ctrl   <= bus.Control;
                        r_cnt    <= bus.Amount;
                        r_cout   <= 1'b0;
                        r_err    <= (bus.Control >= C_RSV);
                        // Zero distance and reserved modes complete with the operand unchanged.
                        if ((bus.Amount == {SHAMT_W{1'b0}}) || (bus.Control >= C_RSV)) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_answer <= w_step[WIDTH-1:0];
                    r_cout   <= w_step[WIDTH];
                    r_cnt    <= r_cnt - SHAMT_W'(1);
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.Busy      = (r_state != S_IDLE);
    assign bus.Answer    = r_answer;
    assign bus.Cout      = r_cout;
    assign bus.Err       = r_err;
endmodule

// File: tb/tb_seq_shifter.sv
// Directed plus randomized checks of seq_shifter against a whole-shift
// arithmetic reference model.
module tb_seq_shifter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    seq_shifter_if #(.WIDTH(16)) bus ();

    seq_shifter #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full N-position shift computed in one go on a double-width word.
    function automatic void ref_model(input logic [2:0] c, input logic [15:0] a, input int n,
                                      output logic [15:0] ans, output logic co);
        logic [31:0] t;
        ans = a;
        co  = 1'b0;
        if (c >= 3'd5 || n == 0) return;
        case (c)
            3'd0: begin t = {16'h0000, a} << n; ans = t[15:0];  co = t[16]; end
            3'd1: begin t = {a, 16'h0000} >> n; ans = t[31:16]; co = t[15]; end
            3'd2: begin t = $unsigned($signed({a, 16'h0000}) >>> n); ans = t[31:16]; co = t[15]; end
            3'd3: begin t = {a, a} << n; ans = t[31:16]; co = ans[0]; end
            default: begin t = {a, a} >> n; ans = t[15:0]; co = ans[15]; end
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [2:0] c, input logic [15:0] a,
                          input int n, input int bp);
        logic [15:0] ea;
        logic        ec;
        int          cyc;
        int          exp_lat;
        ref_model(c, a, n, ea, ec);
        exp_lat = (c >= 3'd5) ? 1 : n + 1;
        cyc = 0;
        while (bus.in_ready !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        bus.Control = c; bus.A = a; bus.Amount = 4'(n);
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.Control = 3'($urandom); bus.A = 16'($urandom); bus.Amount = 4'($urandom);
        cyc = 1;
        if (exp_lat > 1) chk({nm, "_busy"}, {29'd0, bus.in_ready, bus.Busy, bus.out_valid}, 32'h2);
        while (bus.out_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        chk({nm, "_lat"}, cyc, exp_lat);
        chk({nm, "_ans"}, {16'h0000, bus.Answer}, {16'h0000, ea});
        chk({nm, "_cout"}, {31'd0, bus.Cout}, {31'd0, ec});
        chk({nm, "_err"}, {31'd0, bus.Err}, {31'd0, (c >= 3'd5)});
        for (int i = 0; i < bp; i++) begin
            bus.in_valid = 1'($urandom);
            bus.A = 16'($urandom); bus.Amount = 4'($urandom); bus.Control = 3'($urandom);
            @(negedge clk);
            chk({nm, "_hold"}, {bus.Answer, 13'd0, bus.in_ready, bus.out_valid, bus.Cout},
                {ea, 13'd0, 1'b0, 1'b1, ec});
        end
        // With backpressure applied, also offer a request on the release edge.
        bus.in_valid = (bp > 0) ? 1'b1 : 1'b0;
        bus.Amount = 4'd0; bus.Control = 3'd0; bus.A = ~ea;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        chk({nm, "_idle"}, {bus.Answer, 13'd0, bus.in_ready, bus.out_valid, bus.Busy},
            {ea, 13'd0, 1'b1, 1'b0, 1'b0});
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.Control = 3'd0; bus.A = 16'h0000; bus.Amount = 4'd0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {29'd0, bus.in_ready, bus.out_valid, bus.Busy}, 32'h4);
        chk("rst_ans", {bus.Answer, 14'd0, bus.Cout, bus.Err}, 32'h0);
        rst = 1'b0;

        run_op("sll3",  3'd0, 16'h000A, 3, 0);
        run_op("sra1",  3'd2, 16'h8009, 1, 0);
        run_op("rol1",  3'd3, 16'h8001, 1, 0);
        run_op("ror4",  3'd4, 16'h0009, 4, 0);
        run_op("srl0",  3'd1, 16'h0009, 0, 0);
        run_op("bp5",   3'd0, 16'h00F3, 2, 5);

        @(negedge clk);
        bus.Control = 3'd0; bus.A = 16'hFFFF; bus.Amount = 4'd15; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {31'd0, bus.Busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst", {bus.Answer, 13'd0, bus.in_ready, bus.out_valid, bus.Busy},
            {16'h0000, 13'd0, 1'b1, 1'b0, 1'b0});
        chk("mid_flags", {30'd0, bus.Cout, bus.Err}, 32'h0);

        run_op("rsv7",  3'd7, 16'h1234, 5, 1);
        run_op("sll15", 3'd0, 16'h8001, 15, 0);
        run_op("sra15", 3'd2, 16'h8000, 15, 0);
        run_op("ror15", 3'd4, 16'h0001, 15, 0);

        for (int k = 0; k < 40; k++) begin
            run_op("rnd", 3'($urandom_range(0, 7)), 16'($urandom),
                   $urandom_range(0, 15), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
